// File: rtl/div_pipe.sv
// rtl/div_pipe.sv - pipelined unsigned fixed-point divider o = floor(a*2^O_F_W / b)
module div_pipe #(
    parameter int A_W   = 20,
    parameter int B_W   = 22,
    parameter int O_I_W = 0,
    parameter int O_F_W = 32,
    parameter int BPS   = 2,
    parameter int TAG_W = 1,
    parameter int O_W   = O_I_W + O_F_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [O_W-1:0]   o,
    output logic [TAG_W-1:0] out_tag,
    output logic             dz,
    output logic             ovf
);

    localparam int N  = O_W / BPS;
    // Compare width wide enough to hold both a and b*2^O_I_W without truncation
    localparam int CW = ((A_W > B_W + O_I_W) ? A_W : B_W + O_I_W) + 1;
    // Conceptual dividend a*2^O_F_W, consumed one bit per quotient bit
    localparam int DW = A_W + O_F_W;

    // Resolve BPS quotient bits (MSB first) starting at pipeline step s.
    // The remainder is kept below b, so one guard bit suffices for the compare.
    function automatic logic [B_W+O_W-1:0] step(
        input logic [B_W-1:0] rem_i,
        input logic [O_W-1:0] q_i,
        input logic [A_W-1:0] a_i,
        input logic [B_W-1:0] b_i,
        input int             s
    );
        logic [DW-1:0]  d_ext;
        logic [B_W:0]   t;
        logic [B_W-1:0] rem;
        logic [O_W-1:0] q;
        logic           ge;
        d_ext = DW'(a_i) << O_F_W;
        rem   = rem_i;
        q     = q_i;
        t     = '0;
        ge    = 1'b0;
        for (int j = 0; j < BPS; j++) begin
            t   = {rem, |(d_ext & (DW'(1) << (O_W - 1 - s * BPS - j)))};
            ge  = (t >= {1'b0, b_i});
            if (ge) begin
                t = t - {1'b0, b_i};
            end
            rem = t[B_W-1:0];
            q   = {q[O_W-2:0], ge};
        end
        return {rem, q};
    endfunction

    logic [CW-1:0] a_ext;
    logic [CW-1:0] b_sh;
    logic          pre_dz;
    logic          pre_ovf;

    // Divide-by-zero and overflow are decided up front on the raw operands
    always_comb begin
        a_ext   = CW'(a);
        b_sh    = CW'(b) << O_I_W;
        pre_dz  = (b == '0);
        pre_ovf = !pre_dz && (a_ext >= b_sh);
    end

    for (genvar s = 0; s < N; s++) begin : g_st
        logic             v;
        logic [A_W-1:0]   a_r;
        logic [B_W-1:0]   b_r;
        logic [TAG_W-1:0] tag_r;
        logic             dz_r;
        logic             ovf_r;
        logic [B_W-1:0]   rem_r;
        logic [O_W-1:0]   q_r;

        if (s == 0) begin : g_ld
            // Pre stage: capture operands; remainder starts at the integer-aligned dividend
            always_ff @(posedge clk) begin
                if (rst) begin
                    v <= 1'b0;
                end else if (ce) begin
                    v     <= in_valid;
                    a_r   <= a;
                    b_r   <= b;
                    tag_r <= in_tag;
                    dz_r  <= pre_dz;
                    ovf_r <= pre_ovf;
                    rem_r <= B_W'(a >> O_I_W);
                    q_r   <= '0;
                end
            end
        end else begin : g_ld
            // Division stage: retire BPS quotient bits from the previous stage's state
            always_ff @(posedge clk) begin
                if (rst) begin
                    v <= 1'b0;
                end else if (ce) begin
                    v            <= g_st[s-1].v;
                    a_r          <= g_st[s-1].a_r;
                    b_r          <= g_st[s-1].b_r;
                    tag_r        <= g_st[s-1].tag_r;
                    dz_r         <= g_st[s-1].dz_r;
                    ovf_r        <= g_st[s-1].ovf_r;
                    {rem_r, q_r} <= step(g_st[s-1].rem_r, g_st[s-1].q_r,
                                         g_st[s-1].a_r, g_st[s-1].b_r, s - 1);
                end
            end
        end
    end

    // Output register: final step, saturation, and hold of the last result across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            o         <= '0;
            out_tag   <= '0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
        end else if (ce) begin
            out_valid <= g_st[N-1].v;
            if (g_st[N-1].v) begin
                out_tag <= g_st[N-1].tag_r;
                dz      <= g_st[N-1].dz_r;
                ovf     <= g_st[N-1].ovf_r;
                if (g_st[N-1].dz_r || g_st[N-1].ovf_r) begin
                    o <= '1;
                end else begin
                    o <= O_W'(step(g_st[N-1].rem_r, g_st[N-1].q_r,
                                   g_st[N-1].a_r, g_st[N-1].b_r, N - 1));
                end
            end
        end
    end

endmodule

// File: tb/tb_div_pipe.sv
// tb/tb_div_pipe.sv - self-checking bench for div_pipe against a queue-based reference
module tb_div_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ce;

    logic        v0;
    logic [19:0] a0;
    logic [21:0] b0;
    logic [7:0]  t0;
    logic        ov0;
    logic [31:0] o0;
    logic [7:0]  ot0;
    logic        dz0;
    logic        ovf0;

    logic        v1;
    logic [19:0] a1;
    logic [21:0] b1;
    logic [0:0]  t1;
    logic        ov1;
    logic [15:0] o1;
    logic [0:0]  ot1;
    logic        dz1;
    logic        ovf1;

    div_pipe #(.TAG_W(8)) dut0 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v0), .a(a0), .b(b0), .in_tag(t0),
        .out_valid(ov0), .o(o0), .out_tag(ot0), .dz(dz0), .ovf(ovf0)
    );

    div_pipe #(.O_I_W(4), .O_F_W(12), .BPS(1), .TAG_W(1)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v1), .a(a1), .b(b1), .in_tag(t1),
        .out_valid(ov1), .o(o1), .out_tag(ot1), .dz(dz1), .ovf(ovf1)
    );

    typedef struct {
        int unsigned cyc;
        logic [31:0] o;
        logic [7:0]  tag;
        logic        dz;
        logic        ovf;
    } op_t;

    op_t q0[$];
    op_t q1[$];

    logic        ev0, edz0, eovf0;
    logic [31:0] eo0;
    logic [7:0]  et0;
    logic        ev1, edz1, eovf1;
    logic [31:0] eo1;
    logic [7:0]  et1;

    int unsigned cyc = 0;
    int ntests = 0;
    int nfail  = 0;

    function automatic op_t ref_op(logic [19:0] a, logic [21:0] b, logic [7:0] tag, int oiw, int ofw);
        op_t r;
        longint unsigned lim, qv;
        lim   = 64'd1 << (oiw + ofw);
        r.cyc = cyc;
        r.tag = tag;
        r.dz  = (b == 0);
        r.ovf = 1'b0;
        if (b == 0) begin
            r.o = 32'(lim - 1);
        end else begin
            qv = ({44'd0, a} << ofw) / {42'd0, b};
            if (qv >= lim) begin
                r.ovf = 1'b1;
                r.o   = 32'(lim - 1);
            end else begin
                r.o = 32'(qv);
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
            {ev0, eo0, et0, edz0, eovf0} = '0;
            {ev1, eo1, et1, edz1, eovf1} = '0;
        end else if (ce) begin
            cyc++;
            if (v0) q0.push_back(ref_op(a0, b0, t0, 0, 32));
            if (v1) q1.push_back(ref_op(a1, b1, {7'd0, t1}, 4, 12));
            ev0 = 1'b0;
            if (q0.size() > 0 && q0[0].cyc + 16 == cyc) begin
                ev0 = 1'b1; eo0 = q0[0].o; et0 = q0[0].tag; edz0 = q0[0].dz; eovf0 = q0[0].ovf;
                void'(q0.pop_front());
            end
            ev1 = 1'b0;
            if (q1.size() > 0 && q1[0].cyc + 16 == cyc) begin
                ev1 = 1'b1; eo1 = q1[0].o; et1 = q1[0].tag; edz1 = q1[0].dz; eovf1 = q1[0].ovf;
                void'(q1.pop_front());
            end
        end
        @(negedge clk);
        chk("out_valid0", ov0, ev0);
        chk("o0", o0, eo0);
        chk("tag0", ot0, et0);
        chk("dz0", dz0, edz0);
        chk("ovf0", ovf0, eovf0);
        chk("out_valid1", ov1, ev1);
        chk("o1", o1, eo1);
        chk("tag1", ot1, et1);
        chk("dz1", dz1, edz1);
        chk("ovf1", ovf1, eovf1);
    endtask

    task automatic run0(input logic [19:0] a, input logic [21:0] b, output int lat);
        ce = 1'b1; v0 = 1'b1; a0 = a; b0 = b; t0 = 8'(a);
        tick();
        v0 = 1'b0; lat = 1;
        while (!ov0 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run1(input logic [19:0] a, input logic [21:0] b, output int lat);
        ce = 1'b1; v1 = 1'b1; a1 = a; b1 = b; t1 = 1'(a);
        tick();
        v1 = 1'b0; lat = 1;
        while (!ov1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    int          lat;
    int          nvalid;
    int unsigned lim;
    logic [31:0] held_o;
    logic [7:0]  held_t;
    logic        held_v;

    initial begin
        rst = 1'b1; ce = 1'b1;
        v0 = 1'b0; a0 = '0; b0 = '0; t0 = '0;
        v1 = 1'b0; a1 = '0; b1 = '0; t1 = '0;
        tick();
        tick();
        chk("reset_o0", o0, 32'h0);
        chk("reset_valid0", ov0, 1'b0);
        rst = 1'b0;
        tick();

        run0(20'd1, 22'd2, lat);
        chk("lat_1_2", lat, 17);
        chk("o_1_2", o0, 32'h80000000);
        chk("dz_1_2", dz0, 1'b0);
        chk("ovf_1_2", ovf0, 1'b0);
        run0(20'd1, 22'd3, lat);
        chk("o_1_3", o0, 32'h55555555);
        run0(20'd5, 22'd5, lat);
        chk("ovf_5_5", ovf0, 1'b1);
        chk("o_5_5", o0, 32'hFFFFFFFF);
        run0(20'd7, 22'd0, lat);
        chk("dz_7_0", dz0, 1'b1);
        chk("ovf_7_0", ovf0, 1'b0);
        chk("o_7_0", o0, 32'hFFFFFFFF);

        run1(20'd10, 22'd4, lat);
        chk("lat1_10_4", lat, 17);
        chk("o1_10_4", o1, 16'h2800);
        run1(20'd64, 22'd4, lat);
        chk("ovf1_64_4", ovf1, 1'b1);
        chk("o1_64_4", o1, 16'hFFFF);
        run1(20'd63, 22'd4, lat);
        chk("o1_63_4", o1, 16'hFC00);
        chk("ovf1_63_4", ovf1, 1'b0);

        // back-to-back stream of in-range operands with incrementing tags
        nvalid = 0;
        for (int i = 0; i < 64; i++) begin
            b0  = 22'($urandom_range(1, 32'h3FFFFF));
            lim = (32'(b0) - 1 > 32'hFFFFF) ? 32'hFFFFF : 32'(b0) - 1;
            a0  = 20'($urandom_range(0, lim));
            t0  = 8'(i);
            v0  = 1'b1;
            tick();
            if (ov0) nvalid++;
        end
        v0 = 1'b0;
        repeat (20) begin
            tick();
            if (ov0) nvalid++;
        end
        chk("b2b_count", nvalid, 64);

        // random clock-enable stalls with a random operation stream on both instances
        for (int i = 0; i < 150; i++) begin
            ce = ($urandom_range(0, 9) >= 3);
            v0 = 1'($urandom_range(0, 1));
            a0 = 20'($urandom);
            case ($urandom_range(0, 9))
                0:       b0 = '0;
                1, 2:    b0 = 22'($urandom_range(1, 16));
                default: b0 = 22'($urandom);
            endcase
            t0 = 8'(i);
            v1 = 1'($urandom_range(0, 1));
            a1 = 20'($urandom_range(0, 300));
            b1 = 22'($urandom_range(0, 20));
            t1 = 1'($urandom);
            held_o = o0; held_t = ot0; held_v = ov0;
            tick();
            if (!ce) begin
                chk("frozen_o0", o0, held_o);
                chk("frozen_tag0", ot0, held_t);
                chk("frozen_valid0", ov0, held_v);
            end
        end
        ce = 1'b1; v0 = 1'b0; v1 = 1'b0;
        repeat (20) tick();

        // reset with operations in flight
        for (int i = 0; i < 10; i++) begin
            v0 = 1'b1; a0 = 20'(i + 1); b0 = 22'(i + 3); t0 = 8'(i);
            v1 = 1'b1; a1 = 20'(i); b1 = 22'(i + 1); t1 = 1'(i);
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_o0", o0, 32'h0);
        chk("rst_valid0", ov0, 1'b0);
        chk("rst_o1", o1, 16'h0);
        rst = 1'b0;
        run0(20'd3, 22'd4, lat);
        chk("lat_after_rst", lat, 17);
        chk("o_after_rst", o0, 32'hC0000000);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
